// File: rtl/cpu_if_fifo_bridge_if.sv
// CPU/fabric handshake bundle for the bridge: two data channels plus their occupancy levels.
// master is the CPU+fabric side that drives requests; slave is the bridge itself.
interface cpu_if_fifo_bridge_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] O_top;
  logic                  O_top_valid;
  logic                  O_top_ready;
  logic [DATA_WIDTH-1:0] O;
  logic                  O_valid;
  logic                  O_ready;
  logic [DATA_WIDTH-1:0] I;
  logic                  I_valid;
  logic                  I_ready;
  logic [DATA_WIDTH-1:0] I_top;
  logic                  I_top_valid;
  logic                  I_top_ready;
  logic [LW-1:0]         O_level;
  logic [LW-1:0]         I_level;

  modport master (
    output O_top, O_top_valid, O_ready, I, I_valid, I_top_ready,
    input  O_top_ready, O, O_valid, I_ready, I_top, I_top_valid, O_level, I_level
  );

  modport slave (
    input  O_top, O_top_valid, O_ready, I, I_valid, I_top_ready,
    output O_top_ready, O, O_valid, I_ready, I_top, I_top_valid, O_level, I_level
  );
endinterface

// File: rtl/cpu_if_fifo_bridge.sv
// CPU<->fabric bridge: per channel either a 1-cycle registered passthrough or a FWFT FIFO (1-cycle latency).
// Backpressure: ready = FIFO not full, valid = FIFO not empty; passthrough mode ignores handshakes.
module cpu_if_fifo_bridge #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 4,
  parameter int NoConfigBits = 2
) (
  input  logic                    UserCLK,
  input  logic                    RST,
  input  logic [NoConfigBits-1:0] ConfigBits,
  cpu_if_fifo_bridge_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CH_O = 0;
  localparam int CH_I = 1;

  logic mode;
  logic f2c_en;
  logic mode_q;
  logic armed_q;
  logic mode_change;

  logic [DATA_WIDTH-1:0] o_pass_q;
  logic [DATA_WIDTH-1:0] i_pass_q;

  logic [1:0]                 push;
  logic [1:0]                 pop;
  logic [1:0]                 not_full;
  logic [1:0]                 not_empty;
  logic [1:0][DATA_WIDTH-1:0] wdata;
  logic [1:0][DATA_WIDTH-1:0] rdata;
  logic [1:0][LW-1:0]         level;

  assign mode   = ConfigBits[0];
  assign f2c_en = ConfigBits[1];

  // armed_q keeps the reset value of mode_q from looking like a mode change on the first edge.
  assign mode_change = armed_q && (mode != mode_q);

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      mode_q   <= 1'b0;
      armed_q  <= 1'b0;
      o_pass_q <= '0;
      i_pass_q <= '0;
    end else begin
      mode_q   <= mode;
      armed_q  <= 1'b1;
      o_pass_q <= bus.O_top;
      i_pass_q <= bus.I;
    end
  end

  assign wdata[CH_O] = bus.O_top;
  assign wdata[CH_I] = bus.I;

  assign push[CH_O] = mode && bus.O_top_valid && not_full[CH_O];
  assign pop[CH_O]  = mode && bus.O_ready && not_empty[CH_O];
  assign push[CH_I] = mode && f2c_en && bus.I_valid && not_full[CH_I];
  assign pop[CH_I]  = mode && f2c_en && bus.I_top_ready && not_empty[CH_I];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         lvl_q;

    assign not_full[c]  = (lvl_q != LW'(DEPTH));
    assign not_empty[c] = (lvl_q != '0);
    assign level[c]     = lvl_q;
    // An empty FIFO reads 0 so unreset storage never leaks onto the bus.
    assign rdata[c]     = not_empty[c] ? mem[rd_ptr] : '0;

    always_ff @(posedge UserCLK) begin
      if (push[c] && !mode_change) begin
        mem[wr_ptr] <= wdata[c];
      end
    end

    // Pointers are AW bits wide, so incrementing wraps modulo DEPTH.
    always_ff @(posedge UserCLK or posedge RST) begin
      if (RST) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        lvl_q  <= '0;
      end else if (mode_change) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        lvl_q  <= '0;
      end else begin
        if (push[c]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[c])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[c], pop[c]})
          2'b10:   lvl_q <= lvl_q + 1'b1;
          2'b01:   lvl_q <= lvl_q - 1'b1;
          default: lvl_q <= lvl_q;
        endcase
      end
    end
  end

  always_comb begin
    bus.O_top_ready = 1'b1;
    bus.O_valid     = 1'b1;
    bus.O           = o_pass_q;
    bus.O_level     = '0;
    bus.I_ready     = 1'b1;
    bus.I_top_valid = 1'b1;
    bus.I_top       = i_pass_q;
    bus.I_level     = '0;
    if (mode) begin
      bus.O_top_ready = not_full[CH_O];
      bus.O_valid     = not_empty[CH_O];
      bus.O           = rdata[CH_O];
      bus.O_level     = level[CH_O];
      bus.I_ready     = not_full[CH_I];
      bus.I_top_valid = not_empty[CH_I];
      bus.I_top       = rdata[CH_I];
      bus.I_level     = level[CH_I];
    end
    // A disabled fabric-to-CPU channel is silenced but keeps its contents.
    if (!f2c_en) begin
      bus.I_ready     = 1'b0;
      bus.I_top_valid = 1'b0;
      bus.I_top       = '0;
    end
  end
endmodule

// File: tb/tb_cpu_if_fifo_bridge.sv
// Self-checking bench for cpu_if_fifo_bridge: vector table, directed corner sequences, random vs queue model.
module tb_cpu_if_fifo_bridge;
  localparam int DW = 16;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [1:0] cfg;
  int         n_cmp;
  int         n_bad;

  cpu_if_fifo_bridge_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  cpu_if_fifo_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NoConfigBits(2)) dut (
    .UserCLK    (clk),
    .RST        (rst),
    .ConfigBits (cfg),
    .bus        (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          vld;
    logic [DW-1:0] dat;
    logic          rdy;
    logic [2:0]    exp_lvl;
    logic          exp_vld;
    logic [DW-1:0] exp_dat;
    logic          exp_trdy;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.O_top       = '0;
    bus.O_top_valid = 1'b0;
    bus.O_ready     = 1'b0;
    bus.I           = '0;
    bus.I_valid     = 1'b0;
    bus.I_top_ready = 1'b0;
  endtask

  logic [DW-1:0] oq[$];
  logic [DW-1:0] iq[$];
  logic [DW-1:0] v;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    cfg = 2'b11;
    idle_inputs();

    tbl[0] = '{1'b1, 16'h1111, 1'b0, 3'd1, 1'b1, 16'h1111, 1'b1};
    tbl[1] = '{1'b1, 16'h2222, 1'b0, 3'd2, 1'b1, 16'h1111, 1'b1};
    tbl[2] = '{1'b1, 16'h3333, 1'b0, 3'd3, 1'b1, 16'h1111, 1'b1};
    tbl[3] = '{1'b1, 16'h4444, 1'b0, 3'd4, 1'b1, 16'h1111, 1'b0};
    tbl[4] = '{1'b1, 16'h5555, 1'b0, 3'd4, 1'b1, 16'h1111, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 3'd3, 1'b1, 16'h2222, 1'b1};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 3'd2, 1'b1, 16'h3333, 1'b1};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 3'd1, 1'b1, 16'h4444, 1'b1};
    tbl[8] = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b1};
    tbl[9] = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b1};

    // Reset state, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_O", bus.O, 0);
    chk("rst_O_valid", bus.O_valid, 0);
    chk("rst_O_top_ready", bus.O_top_ready, 1);
    chk("rst_O_level", bus.O_level, 0);
    chk("rst_I_top", bus.I_top, 0);
    chk("rst_I_top_valid", bus.I_top_valid, 0);
    chk("rst_I_ready", bus.I_ready, 1);
    chk("rst_I_level", bus.I_level, 0);
    #4 rst = 1'b0;

    // Fill to full, drop the fifth push, drain in order; row 0 is the first edge after reset.
    for (int i = 0; i < 10; i++) begin
      bus.O_top_valid = tbl[i].vld;
      bus.O_top       = tbl[i].dat;
      bus.O_ready     = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_level", i), bus.O_level, tbl[i].exp_lvl);
      chk($sformatf("tbl%0d_valid", i), bus.O_valid, tbl[i].exp_vld);
      chk($sformatf("tbl%0d_O", i), bus.O, tbl[i].exp_dat);
      chk($sformatf("tbl%0d_top_ready", i), bus.O_top_ready, tbl[i].exp_trdy);
    end
    idle_inputs();

    // Steady push+pop at level 2 across several pointer wraps.
    oq.delete();
    for (int k = 0; k < 2; k++) begin
      bus.O_top_valid = 1'b1;
      bus.O_top = 16'h0A00 + 16'(k);
      oq.push_back(bus.O_top);
      step();
    end
    chk("pp_fill_level", bus.O_level, 2);
    for (int k = 2; k < 12; k++) begin
      bus.O_top_valid = 1'b1;
      bus.O_top = 16'h0A00 + 16'(k);
      bus.O_ready = 1'b1;
      void'(oq.pop_front());
      oq.push_back(bus.O_top);
      step();
      chk($sformatf("pp%0d_level", k), bus.O_level, 2);
      chk($sformatf("pp%0d_O", k), bus.O, oq[0]);
    end
    bus.O_top_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      void'(oq.pop_front());
      step();
      chk($sformatf("pp_drain%0d_O", k), bus.O, (oq.size() != 0) ? oq[0] : 16'h0);
    end
    chk("pp_drain_level", bus.O_level, 0);
    idle_inputs();

    // Fabric-to-CPU channel disable keeps contents and resumes in order.
    bus.I_valid = 1'b1;
    bus.I = 16'hB001;
    step();
    bus.I = 16'hB002;
    step();
    chk("f2c_level2", bus.I_level, 2);
    chk("f2c_head", bus.I_top, 16'hB001);
    cfg = 2'b01;
    bus.I = 16'hB003;
    bus.I_top_ready = 1'b1;
    step();
    chk("f2c_off_level", bus.I_level, 2);
    chk("f2c_off_valid", bus.I_top_valid, 0);
    chk("f2c_off_ready", bus.I_ready, 0);
    chk("f2c_off_data", bus.I_top, 0);
    cfg = 2'b11;
    bus.I_valid = 1'b0;
    bus.I_top_ready = 1'b0;
    step();
    chk("f2c_on_valid", bus.I_top_valid, 1);
    chk("f2c_on_data0", bus.I_top, 16'hB001);
    bus.I_top_ready = 1'b1;
    step();
    chk("f2c_on_data1", bus.I_top, 16'hB002);
    chk("f2c_on_level1", bus.I_level, 1);
    step();
    chk("f2c_empty_valid", bus.I_top_valid, 0);
    chk("f2c_empty_data", bus.I_top, 0);
    idle_inputs();

    // Mode switch flushes; passthrough registers every cycle.
    bus.O_top_valid = 1'b1;
    bus.I_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.O_top = 16'hC001 + 16'(k);
      bus.I = 16'hC101 + 16'(k);
      step();
    end
    chk("mode_pre_level", bus.O_level, 3);
    cfg = 2'b10;
    bus.O_top_valid = 1'b0;
    bus.I_valid = 1'b0;
    bus.O_top = 16'hABCD;
    bus.I = 16'h1234;
    step();
    chk("pass_O_level", bus.O_level, 0);
    chk("pass_I_level", bus.I_level, 0);
    chk("pass_O", bus.O, 16'hABCD);
    chk("pass_O_valid", bus.O_valid, 1);
    chk("pass_O_top_ready", bus.O_top_ready, 1);
    chk("pass_I_top", bus.I_top, 16'h1234);
    chk("pass_I_top_valid", bus.I_top_valid, 1);
    chk("pass_I_ready", bus.I_ready, 1);
    bus.O_top = 16'h5A5A;
    step();
    chk("pass_O_next", bus.O, 16'h5A5A);
    cfg = 2'b11;
    bus.O_top_valid = 1'b1;
    bus.O_top = 16'hDEAD;
    step();
    chk("back_O_level", bus.O_level, 0);
    chk("back_O_valid", bus.O_valid, 0);
    chk("back_O", bus.O, 0);
    bus.O_top_valid = 1'b0;
    step();
    chk("back_still_empty", bus.O_valid, 0);
    idle_inputs();

    // Asynchronous reset between edges with 3 words buffered.
    bus.O_top_valid = 1'b1;
    bus.I_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.O_top = 16'hD001 + 16'(k);
      bus.I = 16'hD101 + 16'(k);
      step();
    end
    chk("ar_pre_level", bus.O_level, 3);
    #3 rst = 1'b1;
    #1;
    chk("ar_O_level", bus.O_level, 0);
    chk("ar_I_level", bus.I_level, 0);
    chk("ar_O", bus.O, 0);
    chk("ar_I_top", bus.I_top, 0);
    chk("ar_O_valid", bus.O_valid, 0);
    chk("ar_I_top_valid", bus.I_top_valid, 0);
    #2 rst = 1'b0;
    bus.I_valid = 1'b0;
    bus.O_top = 16'hD00D;
    step();
    chk("ar_first_push_level", bus.O_level, 1);
    chk("ar_first_push_O", bus.O, 16'hD00D);
    bus.O_top_valid = 1'b0;
    bus.O_ready = 1'b1;
    step();
    chk("ar_drain_level", bus.O_level, 0);

    // Random traffic against queue model.
    oq.delete();
    iq.delete();
    for (int n = 0; n < 400; n++) begin
      logic f2c, o_in, o_out, i_in, i_out;
      f2c = ($urandom_range(0, 7) != 0);
      cfg = {f2c, 1'b1};
      bus.O_top_valid = $urandom_range(0, 1) == 1;
      bus.O_top = DW'($urandom);
      bus.O_ready = ($urandom_range(0, 2) == 0);
      bus.I_valid = $urandom_range(0, 1) == 1;
      bus.I = DW'($urandom);
      bus.I_top_ready = ($urandom_range(0, 2) != 0);
      o_in  = bus.O_top_valid && (oq.size() < DEPTH);
      o_out = bus.O_ready && (oq.size() > 0);
      i_in  = f2c && bus.I_valid && (iq.size() < DEPTH);
      i_out = f2c && bus.I_top_ready && (iq.size() > 0);
      if (o_out) void'(oq.pop_front());
      if (o_in) oq.push_back(bus.O_top);
      if (i_out) void'(iq.pop_front());
      if (i_in) iq.push_back(bus.I);
      step();
      chk("rnd_O_level", bus.O_level, oq.size());
      chk("rnd_O_valid", bus.O_valid, oq.size() != 0);
      v = (oq.size() != 0) ? oq[0] : '0;
      chk("rnd_O", bus.O, v);
      chk("rnd_O_top_ready", bus.O_top_ready, oq.size() != DEPTH);
      chk("rnd_I_level", bus.I_level, iq.size());
      chk("rnd_I_top_valid", bus.I_top_valid, f2c && (iq.size() != 0));
      v = (f2c && iq.size() != 0) ? iq[0] : '0;
      chk("rnd_I_top", bus.I_top, v);
      chk("rnd_I_ready", bus.I_ready, f2c && (iq.size() != DEPTH));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_if_fifo_bridge.md
CPU_IF_FIFO_BRIDGE -- requirements
Module: cpu_if_fifo_bridge

Interface
REQ-001 Parameter DATA_WIDTH, default 16: word width of each channel; legal range 1..32.
REQ-002 Parameter DEPTH, default 4: entries per channel FIFO; power of two, minimum 2.
REQ-003 Parameter NoConfigBits, default 2: configuration bits consumed from the tile config memory.
REQ-004 UserCLK  in  1  the single clock; all state changes on its rising edge.
REQ-005 RST  in  1  reset, asynchronous and active-high.
REQ-006 ConfigBits  in  NoConfigBits  bit0 MODE (0 = registered passthrough, 1 = FIFO handshake); bit1 F2C_EN (fabric-to-CPU channel enable).
REQ-007 O_top  in  DATA_WIDTH  CPU-to-fabric write data.
REQ-008 O_top_valid  in  1  CPU write request.
REQ-009 O_top_ready  out  1  CPU-to-fabric FIFO can accept a word.
REQ-010 O  out  DATA_WIDTH  CPU-to-fabric data toward the switch matrix.
REQ-011 O_valid  out  1  O holds a valid word.
REQ-012 O_ready  in  1  fabric accepts O.
REQ-013 I  in  DATA_WIDTH  fabric-to-CPU data from the switch matrix.
REQ-014 I_valid  in  1  fabric write request.
REQ-015 I_ready  out  1  fabric-to-CPU FIFO can accept a word.
REQ-016 I_top  out  DATA_WIDTH  fabric-to-CPU data toward the CPU.
REQ-017 I_top_valid  out  1  I_top holds a valid word.
REQ-018 I_top_ready  in  1  CPU accepts I_top.
REQ-019 O_level, I_level  out  clog2(DEPTH)+1 each  current occupancy of each FIFO.

Function
REQ-020 Each channel SHALL contain a DEPTH-entry FIFO with write pointer, read pointer and occupancy counter; the pointers SHALL wrap modulo DEPTH.
REQ-021 In MODE=1, a push SHALL occur when the input valid and ready signals are both high at a clock edge; a pop SHALL occur when the output valid and ready signals are both high at a clock edge.
REQ-022 Each input ready SHALL equal level != DEPTH; each output valid SHALL equal level != 0; both are combinational from the level.
REQ-023 Each output data SHALL present the entry at the read pointer, so the FIFO behaves first-word-fall-through.
REQ-024 A word pushed at edge n SHALL appear on the output data with output valid high after edge n; minimum latency is 1 cycle.
REQ-025 A simultaneous push and pop SHALL leave the level unchanged and advance both pointers; this is legal at any level 1..DEPTH-1.
REQ-026 When full, a push attempt SHALL be ignored (ready is low) with no data corruption; when empty, a pop attempt SHALL be ignored (valid is low).
REQ-027 In MODE=0, O SHALL register O_top every cycle and I_top SHALL register I every cycle; O_valid, I_top_valid, O_top_ready and I_ready SHALL be held at 1; the levels SHALL read 0; the handshake inputs SHALL be ignored.
REQ-028 A MODE change, detected against a registered copy of MODE, SHALL flush both FIFOs in that same cycle: pointers and levels go to 0, and any push or pop in that cycle is discarded.
REQ-029 When F2C_EN=0, the fabric-to-CPU channel SHALL hold I_ready=0, I_top_valid=0 and I_top=0; its FIFO contents SHALL be retained and become visible again when F2C_EN returns to 1.
REQ-030 No output SHALL have a combinational path from O_top or I to O or I_top.

Reset
REQ-031 While RST=1, all pointers, levels, the registered MODE copy, O and I_top SHALL be 0, independent of UserCLK.
REQ-032 The ready and valid outputs during reset SHALL follow REQ-022, REQ-027 and REQ-029 using level 0.
REQ-033 Deassertion of RST mid-transfer SHALL discard all buffered words; the first edge after deassertion SHALL behave as a normal cycle.
REQ-034 FIFO storage need not be reset, but an empty FIFO's data output SHALL read 0 after reset.

Verification
REQ-035 MODE=1, DEPTH=4: push 0x1111, 0x2222, 0x3333, 0x4444 with O_ready=0 -> O_level=4, O_top_ready=0; then a 5th push of 0x5555 is dropped; then O_ready=1 -> O reads 0x1111..0x4444 in order, O_valid drops after the 4th word.
REQ-036 MODE=1, level 2, simultaneous push and pop for 10 cycles -> level stays 2, output order matches input order, and the pointers wrap correctly.
REQ-037 MODE=0: drive O_top=0xABCD at edge n -> O=0xABCD after edge n, O_valid=1, O_top_ready=1, O_level=0.
REQ-038 MODE=1 with 3 words buffered, switch MODE to 0 -> both levels read 0 on the next cycle; switch back to 1 -> O_valid=0.
REQ-039 F2C_EN=0 with I_level=2 -> I_top_valid=0 and I_ready=0; set F2C_EN=1 -> both buffered words drain in order to I_top.
REQ-040 Assert RST asynchronously between clock edges while level=3 -> levels, O and I_top read 0 immediately, and O_valid=0.
